// File: rtl/sound_scheduler.sv
// Sound-effect scheduler for the Tetris game: latches game event strobes,
// issues the highest-priority pending effect to the single effect player,
// waits for it to finish, enforces a silence gap, and locks after game-lost.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   req[3:0]     event strobes: [0] key, [1] landing, [2] row clear, [3] game lost
//   mute         level; discards requests and blocks new issues
//   player_busy  effect player's write_en, high while an effect sounds
//   play         one-cycle issue pulse to the player
//   sound[1:0]   effect code, updated only together with play
//   pending[3:0] latched, not-yet-served requests
//   locked       set once the game-lost effect has completed
module sound_scheduler #(
  parameter int unsigned GAP_CYCLES    = 1000,
  parameter int unsigned START_TIMEOUT = 4,
  parameter int unsigned CNT_W         = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       mute,
  input  logic       player_busy,
  output logic       play,
  output logic [1:0] sound,
  output logic [3:0] pending,
  output logic       locked
);

  localparam logic [1:0] CODE_LOST = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_START,
    S_PLAYING,
    S_GAP,
    S_LOCKED
  } state_t;

  state_t           r_state;
  logic             r_play;
  logic [1:0]       r_sound;
  logic [3:0]       r_pending;
  logic             r_locked;
  logic [CNT_W-1:0] r_cnt;

  state_t           w_state_nxt;
  logic             w_play_nxt;
  logic [1:0]       w_sound_nxt;
  logic [3:0]       w_pending_nxt;
  logic             w_locked_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_dec;
  logic [3:0]       w_req_eff;
  logic [1:0]       w_code;
  logic [3:0]       w_clr;

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_play    <= 1'b0;
      r_sound   <= 2'b00;
      r_pending <= 4'b0000;
      r_locked  <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_play    <= w_play_nxt;
      r_sound   <= w_sound_nxt;
      r_pending <= w_pending_nxt;
      r_locked  <= w_locked_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  // Next-state, counter and pending-set logic
  always_comb begin
    w_state_nxt   = r_state;
    w_play_nxt    = 1'b0;
    w_sound_nxt   = r_sound;
    w_locked_nxt  = r_locked;
    w_cnt_nxt     = r_cnt;
    w_req_eff     = (mute || r_locked) ? 4'b0000 : req;
    w_pending_nxt = r_pending | w_req_eff;
    w_cnt_dec     = (r_cnt == '0) ? '0 : r_cnt - CNT_W'(1);

    if (r_pending[3])      w_code = 2'd3;
    else if (r_pending[2]) w_code = 2'd2;
    else if (r_pending[1]) w_code = 2'd1;
    else                   w_code = 2'd0;
    // Issuing any code also drops a stale key click (bit 0)
    w_clr = (4'b0001 << w_code) | 4'b0001;

    case (r_state)
      S_IDLE: begin
        if (mute) begin
          w_pending_nxt = 4'b0000;
        end else if (r_pending != 4'b0000) begin
          w_play_nxt    = 1'b1;
          w_sound_nxt   = w_code;
          // A same-cycle request re-sets its bit after the clear
          w_pending_nxt = (r_pending & ~w_clr) | w_req_eff;
          w_cnt_nxt     = CNT_W'(START_TIMEOUT);
          w_state_nxt   = S_WAIT_START;
        end
      end
      S_WAIT_START: begin
        if (player_busy) begin
          w_state_nxt = S_PLAYING;
        end else begin
          w_cnt_nxt = w_cnt_dec;
          // Player never started: abandon the effect, no retry
          if (w_cnt_dec == '0) begin
            w_cnt_nxt   = CNT_W'(GAP_CYCLES);
            w_state_nxt = S_GAP;
          end
        end
      end
      S_PLAYING: begin
        if (!player_busy) begin
          w_cnt_nxt   = CNT_W'(GAP_CYCLES);
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        w_cnt_nxt = w_cnt_dec;
        if (w_cnt_dec == '0) begin
          if (r_sound == CODE_LOST) begin
            w_locked_nxt  = 1'b1;
            w_pending_nxt = 4'b0000;
            w_state_nxt   = S_LOCKED;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_LOCKED: begin
        w_pending_nxt = 4'b0000;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign play    = r_play;
  assign sound   = r_sound;
  assign pending = r_pending;
  assign locked  = r_locked;

endmodule
